// File: rtl/rc_osc_mon_pkg.sv
// Shared types and default constants for the RC oscillator monitor.
package rc_osc_mon_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    MEASURE = 2'd2,
    DONE    = 2'd3
  } mon_state_e;

  localparam int unsigned DEF_CNT_W         = 16;
  localparam int unsigned DEF_GATE_CYCLES   = 10000;
  localparam int unsigned DEF_SETTLE_CYCLES = 256;
  localparam int unsigned DEF_SYNC_STAGES   = 2;

  // Width of a down-counter that must hold (max(a,b) - 1); never narrower than 1 bit.
  function automatic int unsigned ctr_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/rc_osc_edge_sync.sv
// Synchronizes the free-running oscillator output into clk and flags its rising edges.
module rc_osc_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic rise_c
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   prev_q;

  // Shift the asynchronous input one stage deeper every cycle.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_i};
  end

  // Synchronizer chain plus one delayed copy of its output for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_c = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/rc_osc_500k_monitor.sv
// Enables the 500 kHz RC oscillator, waits for it to settle, then counts its
// rising edges over a fixed clk window and latches count / range / stuck status.
module rc_osc_500k_monitor
  import rc_osc_mon_pkg::*;
#(
  parameter int unsigned CNT_W         = DEF_CNT_W,
  parameter int unsigned GATE_CYCLES   = DEF_GATE_CYCLES,
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             keep_ena,
  input  logic             osc_in,
  input  logic [CNT_W-1:0] lo_thresh,
  input  logic [CNT_W-1:0] hi_thresh,
  output logic             osc_ena,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             in_range,
  output logic             stuck
);

  localparam int unsigned      CTR_W       = ctr_width(GATE_CYCLES, SETTLE_CYCLES);
  localparam logic [CTR_W-1:0] SETTLE_LOAD = CTR_W'(SETTLE_CYCLES - 1);
  localparam logic [CTR_W-1:0] GATE_LOAD   = CTR_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  mon_state_e       state_q;
  logic [CTR_W-1:0] ctr_q;
  logic [CNT_W-1:0] edge_cnt_q;
  logic [CNT_W-1:0] edge_cnt_d;
  logic             osc_ena_q;
  logic             busy_q;
  logic             done_q;
  logic [CNT_W-1:0] count_q;
  logic             in_range_q;
  logic             stuck_q;

  logic             rise_c;
  logic             enter_meas_c;
  logic             in_range_c;
  logic             stuck_c;

  rc_osc_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_edge_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (osc_in),
    .rise_c  (rise_c)
  );

  assign enter_meas_c = (state_q == SETTLE) && !abort && (ctr_q == '0);

  // Saturating edge count including the current cycle; counts only while measuring.
  always_comb begin
    edge_cnt_d = edge_cnt_q;
    if ((state_q == MEASURE) && rise_c && (edge_cnt_q != CNT_MAX)) begin
      edge_cnt_d = edge_cnt_q + CNT_W'(1);
    end
  end

  // Status of the final count; an inverted threshold pair can never be satisfied.
  always_comb begin
    in_range_c = (lo_thresh <= edge_cnt_d) && (edge_cnt_d <= hi_thresh);
    stuck_c    = (edge_cnt_d == '0);
  end

  // Edge counter, cleared as the window opens.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_cnt_q <= '0;
    end else if (enter_meas_c) begin
      edge_cnt_q <= '0;
    end else begin
      edge_cnt_q <= edge_cnt_d;
    end
  end

  // Sequencer: settle and gate phases share one down-counter; results latch entering DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ctr_q      <= '0;
      osc_ena_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      count_q    <= '0;
      in_range_q <= 1'b0;
      stuck_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && !abort) begin
            state_q   <= SETTLE;
            ctr_q     <= SETTLE_LOAD;
            osc_ena_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        SETTLE: begin
          if (abort) begin
            state_q   <= IDLE;
            osc_ena_q <= 1'b0;
            busy_q    <= 1'b0;
          end else if (ctr_q == '0) begin
            state_q <= MEASURE;
            ctr_q   <= GATE_LOAD;
          end else begin
            ctr_q <= ctr_q - CTR_W'(1);
          end
        end
        MEASURE: begin
          if (abort) begin
            state_q   <= IDLE;
            osc_ena_q <= 1'b0;
            busy_q    <= 1'b0;
          end else if (ctr_q == '0) begin
            state_q    <= DONE;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            count_q    <= edge_cnt_d;
            in_range_q <= in_range_c;
            stuck_q    <= stuck_c;
          end else begin
            ctr_q <= ctr_q - CTR_W'(1);
          end
        end
        DONE: begin
          state_q   <= IDLE;
          osc_ena_q <= keep_ena;
        end
        default: begin
          state_q   <= IDLE;
          osc_ena_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign osc_ena  = osc_ena_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign count    = count_q;
  assign in_range = in_range_q;
  assign stuck    = stuck_q;

endmodule

// File: tb/tb_rc_osc_500k_monitor.sv
// Bench for rc_osc_500k_monitor: scoreboard of expected results checked on each done pulse.
`timescale 1ns/1ps
module tb_rc_osc_500k_monitor;

  localparam int CLK_NS   = 100;
  localparam int GATE     = 10000;
  localparam int SETTLE   = 256;
  localparam int GATE2    = 2000;
  localparam int SETTLE2  = 16;
  localparam int OSC2_P   = 400;

  typedef struct {
    int lo;
    int hi;
    bit inr;
    bit stk;
  } exp_t;

  exp_t q_main[$];
  exp_t q_small[$];

  int tests = 0;
  int fails = 0;
  int prev_lo = 0;
  int prev_hi = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, abort = 1'b0, keep_ena = 1'b0;
  logic osc = 1'b0;
  logic [15:0] lo_th = '0, hi_th = '0;
  logic osc_ena, busy, done, in_range, stuck;
  logic [15:0] count;

  logic start2 = 1'b0;
  logic osc2 = 1'b0;
  logic [7:0] lo2 = '0, hi2 = '0;
  logic osc_ena2, busy2, done2, in_range2, stuck2;
  logic [7:0] count2;

  int  osc_half = 1000;
  bit  osc_run  = 1'b1;

  rc_osc_500k_monitor dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .keep_ena(keep_ena),
    .osc_in(osc), .lo_thresh(lo_th), .hi_thresh(hi_th),
    .osc_ena(osc_ena), .busy(busy), .done(done), .count(count),
    .in_range(in_range), .stuck(stuck)
  );

  rc_osc_500k_monitor #(
    .CNT_W(8), .GATE_CYCLES(GATE2), .SETTLE_CYCLES(SETTLE2), .SYNC_STAGES(2)
  ) dut_small (
    .clk(clk), .rst(rst), .start(start2), .abort(1'b0), .keep_ena(1'b0),
    .osc_in(osc2), .lo_thresh(lo2), .hi_thresh(hi2),
    .osc_ena(osc_ena2), .busy(busy2), .done(done2), .count(count2),
    .in_range(in_range2), .stuck(stuck2)
  );

  always #(CLK_NS/2) clk = ~clk;
  always #(OSC2_P/2) osc2 = ~osc2;

  // Main oscillator: adjustable half period, or held low when stopped.
  initial begin
    forever begin
      if (osc_run) begin
        #(osc_half);
        if (osc_run) osc = ~osc;
      end else begin
        osc = 1'b0;
        #50;
      end
    end
  end

  function automatic void chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic void chk_rng(input string name, input int act, input int lo, input int hi);
    tests++;
    if (act < lo || act > hi) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endfunction

  // Acceptable counts: within +/-1 of window_ns/period_ns, clipped to the counter range.
  function automatic void band(input int p_ns, input int t_ns, input int maxv,
                               output int lo, output int hi);
    if (p_ns == 0) begin
      lo = 0;
      hi = 0;
    end else begin
      lo = (t_ns + p_ns - 1) / p_ns - 1;
      hi = t_ns / p_ns + 1;
      if (lo < 0) lo = 0;
    end
    if (lo > maxv) lo = maxv;
    if (hi > maxv) hi = maxv;
  endfunction

  // Scoreboard monitors: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      if (q_main.size() == 0) begin
        chk("main_unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = q_main.pop_front();
        chk_rng("main_count", int'(count), e.lo, e.hi);
        chk("main_in_range", int'(in_range), int'(e.inr));
        chk("main_stuck", int'(stuck), int'(e.stk));
      end
    end
  end

  always @(negedge clk) begin
    if (done2) begin
      if (q_small.size() == 0) begin
        chk("small_unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = q_small.pop_front();
        chk_rng("small_count", int'(count2), e.lo, e.hi);
        chk("small_in_range", int'(in_range2), int'(e.inr));
        chk("small_stuck", int'(stuck2), int'(e.stk));
      end
    end
  end

  task automatic start_small(input int lo, input int hi);
    exp_t e;
    int bl, bh;
    band(OSC2_P, GATE2 * CLK_NS, 255, bl, bh);
    e.lo = bl;
    e.hi = bh;
    e.inr = (lo <= bl) && (bh <= hi);
    e.stk = 1'b0;
    lo2 = 8'(lo);
    hi2 = 8'(hi);
    q_small.push_back(e);
    @(posedge clk); #1 start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0;
  endtask

  // One measurement on the main DUT. p_ns=0 stops the oscillator.
  task automatic do_run(input int p_ns, input int lo, input int hi, input bit keep,
                        input bit e_inr, input bit poke, input int abort_at,
                        input bit with_small, input int lo_s, input int hi_s);
    int n, busy_n;
    bit got;
    exp_t e;
    osc_run  = (p_ns != 0);
    if (p_ns != 0) osc_half = p_ns / 2;
    lo_th    = 16'(lo);
    hi_th    = 16'(hi);
    keep_ena = keep;
    if (abort_at == 0) begin
      band(p_ns, GATE * CLK_NS, 65535, e.lo, e.hi);
      e.inr = e_inr;
      e.stk = (p_ns == 0);
      q_main.push_back(e);
      prev_lo = e.lo;
      prev_hi = e.hi;
    end
    if (with_small) begin
      fork
        start_small(lo_s, hi_s);
      join_none
    end
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    busy_n = 0;
    got = 1'b0;
    while (n < 12000) begin
      @(negedge clk);
      n++;
      if (busy) busy_n++;
      if (n == 1) chk("osc_ena_on_entry", int'(osc_ena), 1);
      if (done) begin
        got = 1'b1;
        break;
      end
      start = 1'b0;
      abort = 1'b0;
      if (poke && (n == 100 || n == 5000)) start = 1'b1;
      if (abort_at != 0 && n == abort_at) abort = 1'b1;
      if (abort_at != 0 && n == abort_at + 1) begin
        chk("abort_busy_low", int'(busy), 0);
        chk("abort_osc_ena_low", int'(osc_ena), 0);
        chk_rng("abort_count_held", int'(count), prev_lo, prev_hi);
      end
      if (abort_at != 0 && n == abort_at + 5100) break;
    end
    start = 1'b0;
    abort = 1'b0;
    if (abort_at == 0) begin
      chk("done_seen", int'(got), 1);
      chk("done_cycle", n, SETTLE + GATE + 1);
      chk("busy_cycles", busy_n, SETTLE + GATE);
      if (poke) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_done", int'(busy), 0);
      chk("osc_ena_after_done", int'(osc_ena), int'(keep));
      chk("done_single_pulse", int'(done), 0);
    end else begin
      chk("abort_no_done", int'(got), 0);
    end
  endtask

  task automatic rand_run(input bit poke);
    int p, x, mode, lo, hi;
    bit inr;
    p = 2 * int'($urandom_range(1100, 900));
    x = (GATE * CLK_NS) / p;
    mode = int'($urandom_range(2, 0));
    case (mode)
      0: begin lo = x - 10; hi = x + 10; inr = 1'b1; end
      1: begin lo = x + 20; hi = x + 60; inr = 1'b0; end
      default: begin lo = x + 10; hi = x - 10; inr = 1'b0; end
    endcase
    do_run(p, lo, hi, 1'b0, inr, poke, 0, 1'b0, 0, 0);
  endtask

  initial begin
    // Reset held with both oscillators running.
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_osc_ena", int'(osc_ena), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_in_range", int'(in_range), 0);
    chk("rst_stuck", int'(stuck), 0);
    chk("rst_small_count", int'(count2), 0);
    rst = 1'b0;

    // Nominal 500 kHz; small instance saturates in parallel.
    do_run(2000, 480, 520, 1'b0, 1'b1, 1'b0, 0, 1'b1, 200, 255);

    // Stopped oscillator, then again keeping the enable on.
    do_run(0, 480, 520, 1'b0, 1'b0, 1'b0, 0, 1'b1, 10, 100);
    do_run(0, 480, 520, 1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 0);
    repeat (20) @(negedge clk);
    chk("keep_ena_holds", int'(osc_ena), 1);

    // Fresh 500 count (enable already high), then abort mid-window.
    do_run(2000, 480, 520, 1'b0, 1'b1, 1'b0, 0, 1'b0, 0, 0);
    do_run(2000, 480, 520, 1'b1, 1'b0, 1'b0, SETTLE + 5000, 1'b0, 0, 0);

    // Start pokes while busy and in DONE are ignored.
    rand_run(1'b1);

    // Reset during SETTLE clears everything immediately.
    osc_run = 1'b1;
    osc_half = 1000;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (100) @(negedge clk);
    #10 rst = 1'b1;
    #1;
    chk("midrst_osc_ena", int'(osc_ena), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_count", int'(count), 0);
    chk("midrst_in_range", int'(in_range), 0);
    chk("midrst_stuck", int'(stuck), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    rand_run(1'b0);

    repeat (10) @(negedge clk);
    chk("sb_main_drained", q_main.size(), 0);
    chk("sb_small_drained", q_small.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
